// File: rtl/disp_share_ctrl_pkg.sv
// Shared types and constants for the display-sharing controller and its BCD converter.
package disp_share_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [31:0] BCD_MAX     = 32'd99_999_999;
    localparam logic [31:0] ERR_PATTERN = 32'hEEEE_EEEE;
    localparam int          BCD_ITER    = 32;

    // One double-dabble iteration: add 3 to every nibble >= 5, then shift in the next binary bit.
    function automatic logic [31:0] dd_step(input logic [31:0] acc, input logic bit_in);
        logic [31:0] adj;
        adj = acc;
        for (int i = 0; i < 8; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
        return {adj[30:0], bit_in};
    endfunction

endpackage

// File: rtl/disp_share_ctrl_bcd_seq.sv
// Sequential double-dabble: 32 iterations, MSB first, 32-bit binary in, 8 BCD digits out.
module disp_share_ctrl_bcd_seq
    import disp_share_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] din,
    output logic        busy,
    output logic        done,
    output logic [31:0] bcd
);

    logic [31:0] sh;
    logic [31:0] acc;
    logic [5:0]  cnt;

    // bcd is the result of the iteration in flight; done marks the last one, so the
    // consumer captures the final digits on the same edge the iteration completes.
    assign bcd  = dd_step(acc, sh[31]);
    assign done = busy && (cnt == 6'(BCD_ITER - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            sh   <= '0;
            acc  <= '0;
        end else if (start) begin
            sh   <= din;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            acc <= bcd;
            sh  <= {sh[30:0], 1'b0};
            cnt <= cnt + 6'd1;
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/disp_share_ctrl.sv
// Round-robin time-sharing of the 8-digit display among NREQ requesters, with optional BCD view.
module disp_share_ctrl
    import disp_share_ctrl_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int HOLD_W      = 27
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   val,
    input  logic [NREQ-1:0]      dec_mode,
    output logic [NREQ-1:0]      gnt,
    output logic [31:0]          disp_x,
    output logic                 busy,
    output logic                 ovf
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0][31:0] val_a;
    assign val_a = val;

    state_t              state;
    logic [PW-1:0]       rr_ptr;
    logic [HOLD_W-1:0]   hold_cnt;

    logic                win_found;
    logic [PW-1:0]       win_idx;
    logic [PW:0]         scan;
    logic [31:0]         win_val;
    logic                win_dec;

    // Scan from the far end so the nearest requester after rr_ptr overwrites last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            scan = {1'b0, rr_ptr} + (PW+1)'(k);
            if (scan >= (PW+1)'(NREQ))
                scan = scan - (PW+1)'(NREQ);
            if (req[scan[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[PW-1:0];
            end
        end
    end

    assign win_val = val_a[win_idx];
    assign win_dec = dec_mode[win_idx];

    logic        bcd_start;
    logic        bcd_busy_unused;
    logic        bcd_done;
    logic [31:0] bcd_res;

    assign bcd_start = (state == ST_IDLE) && win_found && win_dec && (win_val <= BCD_MAX);

    disp_share_ctrl_bcd_seq u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (bcd_start),
        .din   (win_val),
        .busy  (bcd_busy_unused),
        .done  (bcd_done),
        .bcd   (bcd_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            disp_x   <= '0;
            busy     <= 1'b0;
            ovf      <= 1'b0;
            rr_ptr   <= PW'(NREQ - 1);
            hold_cnt <= '0;
        end else begin
            gnt <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        gnt      <= NREQ'(1) << win_idx;
                        rr_ptr   <= win_idx;
                        ovf      <= 1'b0;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                        if (!win_dec) begin
                            disp_x <= win_val;
                            state  <= ST_HOLD;
                        end else if (win_val > BCD_MAX) begin
                            disp_x <= ERR_PATTERN;
                            ovf    <= 1'b1;
                            state  <= ST_HOLD;
                        end else begin
                            state  <= ST_CONV;
                        end
                    end
                end
                ST_CONV: begin
                    // disp_x keeps the old value until the final digits are ready.
                    if (bcd_done) begin
                        disp_x   <= bcd_res;
                        hold_cnt <= '0;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
